muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide responder beside the single-cycle ALU. The core issues a request
//  (operands + funct3) when the instruction is OP with funct7=0000001 and stalls until the result returns.
//  Radix-2: one shift-add or restore-subtract step per cycle.
//  Valid/ready handshake on request and response.
// PARAMETERS
//  XLEN   32  operand/result width
//  CNT_W  $clog2(XLEN)+1  iteration counter width (derived, not overridden)
// PORTS
//  clk         in   1     rising-edge clock; only clock
//  reset       in   1     synchronous, active-high reset
//  req_valid   in   1     request present
//  req_ready   out  1     unit can accept; high only in IDLE
//  op_a        in   XLEN  rs1 value (multiplicand / dividend)
//  op_b        in   XLEN  rs2 value (multiplier / divisor)
//  funct3      in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  flush       in   1     abort in-flight op (pipeline redirect)
//  rsp_valid   out  1     result available; high only in DONE
//  rsp_ready   in   1     core consumes result
//  rsp_result  out  XLEN  result; stable while rsp_valid && !rsp_ready
//  busy        out  1     high in CALC/FIXUP/DONE
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, busy=0, rsp_result=0, counter=0.
//  FSM: IDLE -(req_valid&&req_ready)-> CALC -(XLEN steps)-> FIXUP -> DONE -(rsp_ready)-> IDLE.
//  Accept edge (cycle 0): latch funct3, operand sign flags, magnitudes (|x| for signed operands), clear acc.
//  CALC cycles 1..XLEN: mul = shift-add into 2*XLEN product; div = restoring step on magnitudes.
//  FIXUP cycle XLEN+1: apply sign: MUL* negate product if signs differ (MULHSU: op_b is unsigned).
//   DIV negates quotient if signs differ. REM takes the dividend's sign.
//   Select low (MUL) or high (MULH*) half.
//  DONE from cycle XLEN+2: rsp_valid=1 until rsp_ready sampled high; IDLE on the following cycle.
//   No new acceptance in that same cycle.
//  Divide by zero: DIV/DIVU -> all ones; REM/REMU -> op_a (unsigned/signed unchanged). No exception.
//  Overflow DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
//  flush high in any state: next state IDLE, rsp_valid=0, no result emitted.
//   flush wins over req_valid in IDLE (no accept that cycle).
//  reset mid-operation: identical to reset values above; partial state discarded.
//  Requests while busy: req_ready=0, request held by core, not dropped.
//  All arithmetic unsigned on magnitudes; product is 2*XLEN bits; remainder is XLEN+1 bits during steps.
// CONFIGURATION
//  MULDIV_FAST_EN defined: at accept, these cases skip CALC/FIXUP and enter DONE next cycle (rsp_valid at cycle 1):
//   divisor==0, DIV overflow, or either mul operand == 0. Results are as specified above.
//  MULDIV_FAST_EN undefined: every op takes full latency (rsp_valid at cycle XLEN+2).
//   FIXUP forces the div-by-zero results.
// STRUCTURE
//  muldiv_pkg: typedef enum logic[2:0] md_op_e (8 funct3 ops), typedef enum md_state_e
//   {IDLE,CALC,FIXUP,DONE}, localparam for funct7 M code 7'b0000001.
//  Sub-module muldiv_signfix: combinational magnitude/negate and half-select used at accept and FIXUP.
//  Top holds FSM, counter, product/remainder/quotient shift registers.
// TESTING
//  MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB; rsp_valid first high exactly 34 cycles after accept.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
//   MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  DIVU 5/0 -> 0xFFFFFFFF; REM 0xFFFFFFF9 % 0 -> 0xFFFFFFF9;
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000 (fast: at cycle 1 iff MULDIV_FAST_EN).
//  Hold rsp_ready=0 for 5 cycles in DONE -> rsp_result/rsp_valid stable; req_ready=0 throughout; IDLE after.
//  flush at cycle 10 of a DIV -> no rsp_valid, req_ready=1 next cycle.
//   reset mid-CALC -> all outputs at reset values; back-to-back request then completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: op encoding, FSM states,
// funct7 decode constant and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } md_state_e;

    function automatic logic op_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // MUL is treated as unsigned: the low half of the product does not depend on signs.
    function automatic logic op_a_signed(input logic [2:0] f);
        return f[2] ? ~f[0] : (f == OP_MULH || f == OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f);
        return f[2] ? ~f[0] : (f == OP_MULH);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes at accept, and result negation plus
// half/quotient/remainder selection at FIXUP.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              a_neg,
    output logic              b_neg,
    input  logic [2:0]        fix_op,
    input  logic              fix_a_neg,
    input  logic              fix_b_neg,
    input  logic              fix_b_zero,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   rem,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    md_op_e            op;

    assign op = md_op_e'(fix_op);

    always_comb begin
        a_neg = op_a_signed(funct3) & op_a[XLEN-1];
        b_neg = op_b_signed(funct3) & op_b[XLEN-1];
        mag_a = a_neg ? -op_a : op_a;
        mag_b = b_neg ? -op_b : op_b;
    end

    // For divides the low half of prod holds the quotient.
    always_comb begin
        prod_s = (fix_a_neg ^ fix_b_neg) ? -prod : prod;
        quo_s  = (fix_a_neg ^ fix_b_neg) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
        rem_s  = fix_a_neg ? -rem : rem;
        case (op)
            OP_MUL:                       result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = fix_b_zero ? '1 : quo_s;
            default:                      result = rem_s;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide unit with valid/ready request and response.
// Optional MULDIV_FAST_EN: zero-operand, divide-by-zero and overflow cases finish one cycle after accept.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [2:0]      funct3,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy,
    output logic [1:0]      state_dbg
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready && !flush;
    // a response transfers on a rising edge where rsp_valid && rsp_ready. The core holds its
    // request stable until it transfers; the unit holds rsp_result stable until it transfers.
    md_state_e         state_q, state_d;
    logic [2:0]        op_q;
    logic              a_neg_q, b_neg_q, b_zero_q;
    logic [XLEN-1:0]   mag_q;
    logic [XLEN-1:0]   rem_q;
    logic [2*XLEN-1:0] prod_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept, last_step;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_result;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   fix_result;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;

    assign accept    = (state_q == IDLE) && req_valid && !flush;
    assign last_step = (cnt_q == CNT_W'(XLEN - 1));

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .op_a       (op_a),
        .op_b       (op_b),
        .funct3     (funct3),
        .mag_a      (mag_a),
        .mag_b      (mag_b),
        .a_neg      (a_neg),
        .b_neg      (b_neg),
        .fix_op     (op_q),
        .fix_a_neg  (a_neg_q),
        .fix_b_neg  (b_neg_q),
        .fix_b_zero (b_zero_q),
        .prod       (prod_q),
        .rem        (rem_q),
        .result     (fix_result)
    );

`ifdef MULDIV_FAST_EN
    always_comb begin
        fast_hit    = 1'b0;
        fast_result = '0;
        if (op_is_div(funct3)) begin
            if (op_b == '0) begin
                fast_hit    = 1'b1;
                fast_result = funct3[1] ? op_a : '1;
            end else if (!funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1) begin
                fast_hit    = 1'b1;
                fast_result = funct3[1] ? '0 : op_a;
            end
        end else if (op_a == '0 || op_b == '0) begin
            fast_hit    = 1'b1;
            fast_result = '0;
        end
    end
`else
    assign fast_hit    = 1'b0;
    assign fast_result = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (req_valid) state_d = fast_hit ? DONE : CALC;
                CALC:    if (last_step) state_d = FIXUP;
                FIXUP:   state_d = DONE;
                DONE:    if (rsp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == DONE) && !flush;
        state_dbg = state_q;
    end

    // Multiply: right-shifting shift-add with multiplier in prod low half.
    // Divide: restoring step, dividend shifts out of prod low half as quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {rem_q, prod_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        div_ge    = ~div_diff[XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            b_zero_q   <= 1'b0;
            mag_q      <= '0;
            rem_q      <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            rsp_result <= '0;
        end else if (accept) begin
            op_q     <= funct3;
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            b_zero_q <= (op_b == '0);
            mag_q    <= op_is_div(funct3) ? mag_b : mag_a;
            prod_q   <= {{XLEN{1'b0}}, (op_is_div(funct3) ? mag_a : mag_b)};
            rem_q    <= '0;
            cnt_q    <= '0;
            if (fast_hit) rsp_result <= fast_result;
        end else if (state_q == CALC && !flush) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (op_is_div(op_q)) begin
                rem_q            <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                prod_q[XLEN-1:0] <= {prod_q[XLEN-2:0], div_ge};
            end else begin
                prod_q <= {mul_sum, prod_q[XLEN-1:1]};
            end
        end else if (state_q == FIXUP && !flush) begin
            rsp_result <= fix_result;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: table of RV32M ops with hand-computed results and
// latencies, plus sequences for response backpressure, flush and mid-operation reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN     = 32;
    localparam int FULL_LAT = XLEN + 2;
`ifdef MULDIV_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid, req_ready;
    logic [XLEN-1:0] op_a, op_b;
    logic [2:0]      funct3;
    logic            flush;
    logic            rsp_valid, rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            busy;
    logic [1:0]      state_dbg;

    muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .funct3     (funct3),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        fast;
    } vec_t;

    localparam int NV = 24;
    vec_t        vecs [NV];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; returns just after the accept edge.
    task automatic send_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        funct3    = f;
        op_a      = a;
        op_b      = b;
        req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_for_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int exp_lat);
        int          cyc = 0;
        bit          got = 1'b0;
        logic [31:0] exp;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            got = rsp_valid;
        end
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({name, "_result"}, rsp_result, exp);
    endtask

    task automatic consume(input string name);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_idle_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int vcount;
        reset = 1'b1; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        op_a = '0; op_b = '0; funct3 = '0;

        vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
        vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        1'b0};
        vecs[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2,         1'b0};
        vecs[8]  = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1};
        vecs[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[12] = '{OP_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[13] = '{OP_MUL,    32'd0,         32'h0001_2345, 32'd0,         1'b1};
        vecs[14] = '{OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'd1,         1'b0};
        vecs[15] = '{OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'd0,         1'b0};
        vecs[16] = '{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
        vecs[17] = '{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
        vecs[18] = '{OP_REMU,   32'hFFFF_FFF9, 32'd2,         32'd1,         1'b0};
        vecs[19] = '{OP_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0};
        vecs[20] = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0};
        vecs[21] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[22] = '{OP_MULH,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[23] = '{OP_REMU,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1};

        // Clock/reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready",  32'(req_ready), 32'd1);
        check("reset_rsp_valid",  32'(rsp_valid), 32'd0);
        check("reset_busy",       32'(busy),      32'd0);
        check("reset_rsp_result", rsp_result,     32'd0);
        check("reset_state",      32'(state_dbg), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < NV; i++) begin
            exp_q.push_back(vecs[i].exp);
            send_req(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_rsp($sformatf("vec%0d", i), (vecs[i].fast && FAST) ? 1 : FULL_LAT);
            consume($sformatf("vec%0d", i));
        end

        // Response backpressure with a second request waiting
        exp_q.push_back(32'd14);
        send_req(OP_DIVU, 32'd100, 32'd7);
        wait_rsp("hold", FULL_LAT);
        funct3 = OP_MUL; op_a = 32'd6; op_b = 32'd9; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_result", rsp_result, 32'd14);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("release_no_accept", 32'(busy), 32'd0);
        check("release_req_ready", 32'(req_ready), 32'd1);
        exp_q.push_back(32'd54);
        send_req(OP_MUL, 32'd6, 32'd9);
        wait_rsp("held_req", FULL_LAT);
        consume("held_req");

        // Flush at cycle 10 of a divide
        send_req(OP_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        check("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_req_ready", 32'(req_ready), 32'd1);
        check("flush_busy",      32'(busy),      32'd0);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        check("flush_no_rsp", 32'(vcount), 32'd0);

        // Flush beats a request in IDLE
        funct3 = OP_MUL; op_a = 32'd3; op_b = 32'd4; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("flush_blocks_accept", 32'(busy), 32'd0);
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);

        // Reset mid-CALC, then a back-to-back request
        send_req(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_req_ready",  32'(req_ready), 32'd1);
        check("midreset_rsp_valid",  32'(rsp_valid), 32'd0);
        check("midreset_busy",       32'(busy),      32'd0);
        check("midreset_rsp_result", rsp_result,     32'd0);
        check("midreset_state",      32'(state_dbg), 32'd0);
        reset = 1'b0;
        exp_q.push_back(32'hFFFF_FFFD);
        send_req(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_rsp("after_reset", FULL_LAT);
        consume("after_reset");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
